// File: rtl/spi_read_buffer_if.sv
// Bundle of the AXI-Stream word input, the loader pop interface and the status outputs
// of spi_read_buffer. The slave modport is the buffer's view; master is the host/loader side.
interface spi_read_buffer_if #(
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [31:0]   s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic [31:0]   spi_data;
  logic          valid_o;
  logic          last_o;
  logic          rb_ready;
  logic          flush_i;
  logic          done_o;
  logic          underrun_o;
  logic [LW-1:0] level_o;
  logic [31:0]   word_cnt_o;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, rb_ready, flush_i,
    output s_tready, spi_data, valid_o, last_o, done_o, underrun_o, level_o, word_cnt_o
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, rb_ready, flush_i,
    input  s_tready, spi_data, valid_o, last_o, done_o, underrun_o, level_o, word_cnt_o
  );
endinterface

// File: rtl/spi_read_buffer.sv
// First-word-fall-through word FIFO with prefill-gated frame FSM feeding the SPI loader.
// Optional macro SPI_RB_BYTE_SWAP_EN byte-reverses each word on write (LE host -> MSB-first).
module spi_read_buffer #(
  parameter int DEPTH   = 16,
  parameter int PREFILL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_read_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
  localparam logic [LW-1:0] PREFILL_L = LW'(PREFILL);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [31:0]   r_mem  [DEPTH];
  logic          r_mlast[DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic [31:0]   r_word_cnt;
  logic          r_underrun;
  logic          r_last_seen;

  logic          w_full;
  logic          w_empty;
  logic          w_tready;
  logic          w_valid;
  logic          w_push;
  logic          w_pop;
  logic          w_head_last;
  logic          w_underrun_set;
  logic [LW-1:0] w_level_inc;
  logic [31:0]   w_wdata;

`ifdef SPI_RB_BYTE_SWAP_EN
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
  assign w_wdata = byte_swap(bus.s_tdata);
`else
  assign w_wdata = bus.s_tdata;
`endif

  assign w_full         = (r_level == DEPTH_L);
  assign w_empty        = (r_level == '0);
  assign w_tready       = !w_full && (r_state != DONE) && !r_last_seen;
  assign w_valid        = (r_state == STREAM) && !w_empty;
  assign w_push         = bus.s_tvalid && w_tready;
  assign w_pop          = bus.rb_ready && w_valid;
  assign w_head_last    = !w_empty && r_mlast[r_rptr];
  assign w_underrun_set = (r_state == STREAM) && bus.rb_ready && w_empty;
  assign w_level_inc    = r_level + 1'b1;

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_push) begin
          w_next_state = (PREFILL_L == LW'(1) || bus.s_tlast) ? STREAM : FILL;
        end
      end
      FILL: begin
        if (w_push && (w_level_inc >= PREFILL_L || bus.s_tlast)) begin
          w_next_state = STREAM;
        end
      end
      STREAM: begin
        if (w_pop && w_head_last) begin
          w_next_state = DONE;
        end
      end
      DONE: w_next_state = DONE;
      default: w_next_state = IDLE;
    endcase
    if (bus.flush_i) begin
      w_next_state = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_word_cnt  <= '0;
      r_underrun  <= 1'b0;
      r_last_seen <= 1'b0;
    end else if (bus.flush_i) begin
      r_state     <= IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_word_cnt  <= '0;
      r_underrun  <= 1'b0;
      r_last_seen <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr     <= r_rptr + 1'b1;
        r_word_cnt <= r_word_cnt + 32'd1;
      end
      if (w_push && !w_pop) begin
        r_level <= w_level_inc;
      end else if (w_pop && !w_push) begin
        r_level <= r_level - 1'b1;
      end
      if (w_underrun_set) begin
        r_underrun <= 1'b1;
      end
      // last_seen blocks further input for the rest of the frame
      if (w_push && bus.s_tlast) begin
        r_last_seen <= 1'b1;
      end else if (r_state == IDLE) begin
        r_last_seen <= 1'b0;
      end
    end
  end

  // Storage array carries no reset; reads of an empty FIFO are masked to zero
  always_ff @(posedge clk) begin
    if (w_push && !bus.flush_i) begin
      r_mem[r_wptr]   <= w_wdata;
      r_mlast[r_wptr] <= bus.s_tlast;
    end
  end

  assign bus.s_tready   = w_tready;
  assign bus.valid_o    = w_valid;
  assign bus.spi_data   = w_empty ? 32'd0 : r_mem[r_rptr];
  assign bus.last_o     = w_head_last;
  assign bus.done_o     = (r_state == DONE);
  assign bus.underrun_o = r_underrun;
  assign bus.level_o    = r_level;
  assign bus.word_cnt_o = r_word_cnt;
endmodule

// File: doc/spi_read_buffer.md
# spi_read_buffer

Word FIFO and frame controller between the host-side AXI-Stream source of program words and the SPI loader. Captures a stream of 32-bit instruction/data words into a first-word-fall-through buffer and presents them to the loader over a valid/ready/last interface. The loader pops exactly one word per `rb_ready` pulse. A prefill threshold prevents the loader from starting before enough words are banked, because the loader does not stall mid-word. The block also reports frame completion, the popped-word count and any underrun.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in 32-bit words; power of two, ≥ 2.
- `PREFILL`, 4: words that must be buffered before `valid_o` first asserts; 1 ≤ PREFILL ≤ DEPTH.

Ports (clock and reset first):
- `clk`  in  1: single clock; all state updates on posedge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `s_tdata`  in  32: input word.
- `s_tvalid`  in  1: input word valid.
- `s_tlast`  in  1: marks the final word of the frame.
- `s_tready`  out  1: block can accept a word this cycle.
- `spi_data`  out  32: head-of-FIFO word to the loader.
- `valid_o`  out  1: `spi_data` is valid and poppable.
- `last_o`  out  1: the head word is the frame's last word.
- `rb_ready`  in  1: pop request from the loader, a one-cycle pulse per consumed word; it may also be held high.
- `flush_i`  in  1: synchronous clear of the FIFO and state, returning to IDLE.
- `done_o`  out  1: the last word has been popped.
- `underrun_o`  out  1: sticky flag, set when a pop is requested in STREAM while the FIFO is empty.
- `level_o`  out  $clog2(DEPTH)+1: number of words stored.
- `word_cnt_o`  out  32: number of words popped since IDLE.

## Operation
- Storage: DEPTH×32 array with read and write pointers of $clog2(DEPTH) bits each, wrapping modulo DEPTH. The level counter is one bit wider than the pointers.
  - full = (level == DEPTH); empty = (level == 0).
  - A tlast flag is stored alongside each word.
- Push occurs when `s_tvalid && s_tready`.
  - `s_tready` = !full && state ∈ {IDLE, FILL, STREAM} && !last_seen.
  - `last_seen` sets when a word with tlast is pushed and clears only in IDLE.
- Pop occurs when `rb_ready && valid_o`.
  - `valid_o` = (state == STREAM) && !empty.
  - `spi_data` and `last_o` come combinationally from the head entry. They hold stable until the pop edge.
- Simultaneous push and pop: both take effect and the level is unchanged. When full, a push is refused even if a pop occurs in the same cycle.
- FSM states:
  - IDLE: FIFO empty, counters cleared. On a push, go to FILL, or go straight to STREAM if PREFILL==1 or the pushed word has tlast.
  - FILL: go to STREAM when post-update level ≥ PREFILL or a tlast word is pushed. `valid_o` stays 0.
  - STREAM: stay even if the FIFO drains. Go to DONE when the word with last_o=1 is popped.
  - DONE: `done_o`=1, `s_tready`=0, `valid_o`=0. Stay until `flush_i`.
- `underrun_o` sets in STREAM when `rb_ready` is high and the FIFO is empty. No pop occurs and the pointers are unchanged. The flag clears only on reset or flush.
- `word_cnt_o` increments by 1 on every pop.
- `flush_i` overrides everything in the same cycle: pointers, level, count and flags go to 0, last_seen clears, state goes to IDLE, and any push or pop that cycle is discarded.

## Timing
- Reset (async assert, sync release) values:
  - state = IDLE; `s_tready` = 1 after reset deasserts.
  - `spi_data` = 0 (empty head reads as 0); `valid_o`, `last_o`, `done_o`, `underrun_o` = 0.
  - `level_o` = 0; `word_cnt_o` = 0.
- Reset mid-frame discards all buffered words.
- Latency, push to `valid_o`: 1 cycle after the push edge that meets the STREAM condition.
- After a pop edge, the next head word is visible on `spi_data` 1 cycle later with no bubble.
- `done_o` rises 1 cycle after the pop edge of the last word.
- Throughput is one push and one pop per cycle.

## Configuration
- `SPI_RB_BYTE_SWAP_EN` defined: each `s_tdata` word is byte-reversed on write, so {b0,b1,b2,b3} is stored as {b3,b2,b1,b0}. This converts little-endian host files to the MSB-first order the loader shifts out.
- Not defined: words are stored unmodified.

## Test plan
- Reset, then push 3 words (tlast on the 3rd) with PREFILL=4 → STREAM is entered on the 3rd push despite level 3; `valid_o`=1 the next cycle with `spi_data`=word 1.
- Push 10 words, then pulse `rb_ready` once every 8 cycles → words pop in order, `word_cnt_o` reaches 10, `last_o`=1 only on word 10, `done_o`=1 one cycle after the final pop, `s_tready`=0 in DONE.
- Fill to DEPTH=16 with no pops → `s_tready`=0, `level_o`=16. Then push and pop in the same cycle → the push is refused and the level drops to 15.
- In STREAM with an empty FIFO, pulse `rb_ready` → `underrun_o`=1, `word_cnt_o` unchanged. Then assert `flush_i` → all state clears and `underrun_o`=0.
- Push 0x11223344 with `SPI_RB_BYTE_SWAP_EN` defined → `spi_data`=0x44332211; without the macro → 0x11223344.
- Deassert `rst_n` with 5 words buffered mid-frame → `valid_o`, `level_o` and `word_cnt_o` drop to 0 immediately (asynchronously); after release, `s_tready`=1.
